inst_fetch: RTL and testbench

Instruction fetch unit for the NPC RISC-V core. It owns the architectural PC and fetches 32-bit instructions from instruction memory over a valid/ready request/response handshake. It delivers each instruction and its PC to the decode stage over a valid/ready handshake, and accepts control-flow redirects from execute and a halt from ebreak.

---
 rtl/inst_fetch_pkg.sv | 20 ++
 rtl/inst_fetch_if.sv | 38 +++
 rtl/Reg.sv | 21 ++
 rtl/inst_fetch.sv | 126 ++++++++++++
 tb/tb_inst_fetch.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the NPC instruction fetch unit: reset PC,
// instruction width and the IFU state encoding.
package inst_fetch_pkg;

    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
    localparam int          INST_W       = 32;

    localparam logic [1:0] IFU_IDLE = 2'd0;
    localparam logic [1:0] IFU_REQ  = 2'd1;
    localparam logic [1:0] IFU_WAIT = 2'd2;
    localparam logic [1:0] IFU_OUT  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = IFU_IDLE,
        S_REQ  = IFU_REQ,
        S_WAIT = IFU_WAIT,
        S_OUT  = IFU_OUT
    } ifu_state_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Bundle of the fetch unit's memory, decode, redirect and halt signals.
// master = fetch unit side, slave = memory/pipeline side.
interface inst_fetch_if #(
    parameter int ADDR_W = 32
);
    import inst_fetch_pkg::*;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_resp_valid;
    logic              imem_resp_ready;
    logic [INST_W-1:0] imem_resp_data;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;
    logic              halted;
    logic              fetch_fault;

    modport master (
        output imem_req_valid, imem_req_addr, imem_resp_ready,
               out_valid, out_inst, out_pc, halted, fetch_fault,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               out_ready, redirect_valid, redirect_pc, halt
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, imem_resp_ready,
               out_valid, out_inst, out_pc, halted, fetch_fault,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               out_ready, redirect_valid, redirect_pc, halt
    );

endinterface

// File: rtl/Reg.sv
// Generic enabled register with synchronous active-high reset.
module Reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_wen,
    output logic [WIDTH-1:0] o_dout
);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_dout <= RESET_VAL;
        end else if (i_wen) begin
            o_dout <= i_din;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, fetches over imem req/resp and hands
// instructions to decode. Optional misaligned-PC trap: IFU_MISALIGN_CHECK_EN.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    inst_fetch_if.master      bus
);

    ifu_state_t        r_state;
    logic              r_kill;
    logic              r_halted;
    logic [INST_W-1:0] r_out_inst;
    logic [ADDR_W-1:0] r_out_pc;

    logic [ADDR_W-1:0] w_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic              w_pc_en;
    logic              w_out_fire;
    logic              w_halt_now;
    logic              w_misaligned;

    assign w_out_fire = (r_state == S_OUT) & bus.out_ready;
    assign w_halt_now = r_halted | bus.halt;
    assign w_pc_plus4 = w_pc + ADDR_W'(4);

    // Redirect overrides the sequential advance in every state.
    assign w_pc_en   = bus.redirect_valid | w_out_fire;
    assign w_pc_next = bus.redirect_valid ? bus.redirect_pc : w_pc_plus4;

    Reg #(
        .WIDTH     (ADDR_W),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst    (rst),
        .i_din  (w_pc_next),
        .i_wen  (w_pc_en),
        .o_dout (w_pc)
    );

`ifdef IFU_MISALIGN_CHECK_EN
    logic r_fault;

    assign w_misaligned      = (w_pc[1:0] != 2'b00);
    assign bus.imem_req_addr = w_pc;
    assign bus.fetch_fault   = r_fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if ((r_state == S_REQ) && w_misaligned) begin
            r_fault <= 1'b1;
        end
    end
`else
    assign w_misaligned      = 1'b0;
    assign bus.imem_req_addr = {w_pc[ADDR_W-1:2], 2'b00};
    assign bus.fetch_fault   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_kill     <= 1'b0;
            r_halted   <= 1'b0;
            r_out_inst <= '0;
            r_out_pc   <= RESET_PC;
        end else begin
            if (bus.halt) begin
                r_halted <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (!w_halt_now) begin
                        r_state <= S_REQ;
                    end
                end
                // A request already presented is allowed to complete even if
                // halt arrives meanwhile; valid is never withdrawn.
                S_REQ: begin
                    if (w_misaligned) begin
                        r_halted <= 1'b1;
                        r_state  <= S_IDLE;
                    end else if (bus.imem_req_ready) begin
                        r_state <= S_WAIT;
                        r_kill  <= bus.redirect_valid;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_resp_valid) begin
                        if (r_kill || bus.redirect_valid) begin
                            r_kill  <= 1'b0;
                            r_state <= w_halt_now ? S_IDLE : S_REQ;
                        end else begin
                            r_out_inst <= bus.imem_resp_data;
                            r_out_pc   <= w_pc;
                            r_state    <= S_OUT;
                        end
                    end else if (bus.redirect_valid) begin
                        r_kill <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (bus.redirect_valid || bus.out_ready) begin
                        r_state <= w_halt_now ? S_IDLE : S_REQ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.imem_req_valid  = (r_state == S_REQ) & ~w_misaligned;
    assign bus.imem_resp_ready = (r_state == S_WAIT);
    assign bus.out_valid       = (r_state == S_OUT);
    assign bus.out_inst        = r_out_inst;
    assign bus.out_pc          = r_out_pc;
    assign bus.halted          = r_halted;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: cycle vector table, directed halt/misalign/reset
// sequences, then random traffic checked against an architectural PC model.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_fetch_if #(.ADDR_W(32)) bus ();

    inst_fetch #(
        .ADDR_W   (32),
        .RESET_PC (32'h8000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        rrdy;
        logic        rvld;
        logic [31:0] rdata;
        logic        ordy;
        logic        redir;
        logic [31:0] rpc;
        logic        e_reqv;
        logic [31:0] e_addr;
        logic        e_respr;
        logic        e_outv;
        logic [31:0] e_opc;
        logic [31:0] e_oinst;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rrdy, input logic rvld, input logic [31:0] rdata,
                         input logic ordy, input logic redir, input logic [31:0] rpc,
                         input logic hlt);
        bus.imem_req_ready  = rrdy;
        bus.imem_resp_valid = rvld;
        bus.imem_resp_data  = rdata;
        bus.out_ready       = ordy;
        bus.redirect_valid  = redir;
        bus.redirect_pc     = rpc;
        bus.halt            = hlt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_valid"},  32'(bus.imem_req_valid),  0);
        chk({tag, "_resp_ready"}, 32'(bus.imem_resp_ready), 0);
        chk({tag, "_out_valid"},  32'(bus.out_valid),       0);
        chk({tag, "_out_inst"},   bus.out_inst,             0);
        chk({tag, "_out_pc"},     bus.out_pc,               32'h8000_0000);
        chk({tag, "_halted"},     32'(bus.halted),          0);
        chk({tag, "_fault"},      32'(bus.fetch_fault),     0);
    endtask

    task automatic addv(input logic rrdy, input logic rvld, input logic [31:0] rdata,
                        input logic ordy, input logic redir, input logic [31:0] rpc,
                        input logic e_reqv, input logic [31:0] e_addr, input logic e_respr,
                        input logic e_outv, input logic [31:0] e_opc, input logic [31:0] e_oinst);
        vec_t v;
        v.rrdy = rrdy; v.rvld = rvld; v.rdata = rdata; v.ordy = ordy;
        v.redir = redir; v.rpc = rpc; v.e_reqv = e_reqv; v.e_addr = e_addr;
        v.e_respr = e_respr; v.e_outv = e_outv; v.e_opc = e_opc; v.e_oinst = e_oinst;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0010_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    logic [31:0] model_pc;
    logic        pending;
    logic [31:0] pend_addr;
    int          lat;
    int          deliveries;
    int          since_fire;
    logic        saw_req;
    logic        rrdy_r, rvld_r, ordy_r, redir_r;
    logic [31:0] rdata_r, rpc_r;
    logic        out_fire, req_fire, resp_fire;

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);

        // Inputs for the coming edge | expected outputs at this step.
        addv(1,0,0,0,0,0,                       0,32'h80000000,0,0,32'h80000000,32'h0);
        addv(1,0,0,0,0,0,                       1,32'h80000000,0,0,32'h80000000,32'h0);
        addv(0,1,32'h00100093,0,0,0,            0,32'h80000000,1,0,32'h80000000,32'h0);
        for (int k = 0; k < 5; k++)
            addv(0,0,0,0,0,0,                   0,32'h80000000,0,1,32'h80000000,32'h00100093);
        addv(0,0,0,1,0,0,                       0,32'h80000000,0,1,32'h80000000,32'h00100093);
        addv(0,0,0,0,0,0,                       1,32'h80000004,0,0,32'h80000000,32'h00100093);
        addv(1,0,0,0,0,0,                       1,32'h80000004,0,0,32'h80000000,32'h00100093);
        addv(0,0,0,0,0,0,                       0,32'h80000004,1,0,32'h80000000,32'h00100093);
        addv(0,1,32'hDEADBEEF,1,0,0,            0,32'h80000004,1,0,32'h80000000,32'h00100093);
        addv(0,0,0,1,0,0,                       0,32'h80000004,0,1,32'h80000004,32'hDEADBEEF);
        addv(1,0,0,0,0,0,                       1,32'h80000008,0,0,32'h80000004,32'hDEADBEEF);
        addv(0,0,0,0,1,32'h80000100,            0,32'h80000008,1,0,32'h80000004,32'hDEADBEEF);
        addv(0,0,0,0,0,0,                       0,32'h80000100,1,0,32'h80000004,32'hDEADBEEF);
        addv(0,1,32'hCAFEF00D,1,0,0,            0,32'h80000100,1,0,32'h80000004,32'hDEADBEEF);
        addv(1,0,0,1,0,0,                       1,32'h80000100,0,0,32'h80000004,32'hDEADBEEF);
        addv(0,1,32'h11111111,0,0,0,            0,32'h80000100,1,0,32'h80000004,32'hDEADBEEF);
        addv(0,0,0,0,1,32'h80000200,            0,32'h80000100,0,1,32'h80000100,32'h11111111);
        addv(1,0,0,0,1,32'h80000300,            1,32'h80000200,0,0,32'h80000100,32'h11111111);
        addv(0,1,32'h22222222,1,0,0,            0,32'h80000300,1,0,32'h80000100,32'h11111111);
        addv(0,0,0,0,1,32'hFFFFFFFC,            1,32'h80000300,0,0,32'h80000100,32'h11111111);
        addv(1,0,0,0,0,0,                       1,32'hFFFFFFFC,0,0,32'h80000100,32'h11111111);
        addv(0,1,32'h33333333,0,0,0,            0,32'hFFFFFFFC,1,0,32'h80000100,32'h11111111);
        addv(0,0,0,1,0,0,                       0,32'hFFFFFFFC,0,1,32'hFFFFFFFC,32'h33333333);
        addv(0,0,0,0,0,0,                       1,32'h00000000,0,0,32'hFFFFFFFC,32'h33333333);

        // ---------------- table-driven cycle vectors ----------------
        do_reset();
        check_reset_vals("reset");
        for (int i = 0; i < vecs.size(); i++) begin
            chk($sformatf("v%0d_req_valid", i),  32'(bus.imem_req_valid),  32'(vecs[i].e_reqv));
            chk($sformatf("v%0d_req_addr", i),   bus.imem_req_addr,        vecs[i].e_addr);
            chk($sformatf("v%0d_resp_ready", i), 32'(bus.imem_resp_ready), 32'(vecs[i].e_respr));
            chk($sformatf("v%0d_out_valid", i),  32'(bus.out_valid),       32'(vecs[i].e_outv));
            chk($sformatf("v%0d_out_pc", i),     bus.out_pc,               vecs[i].e_opc);
            chk($sformatf("v%0d_out_inst", i),   bus.out_inst,             vecs[i].e_oinst);
            $display("vec %0d: req_valid=%0b addr=%h resp_ready=%0b out_valid=%0b out_pc=%h out_inst=%h",
                     i, bus.imem_req_valid, bus.imem_req_addr, bus.imem_resp_ready,
                     bus.out_valid, bus.out_pc, bus.out_inst);
            drive(vecs[i].rrdy, vecs[i].rvld, vecs[i].rdata, vecs[i].ordy,
                  vecs[i].redir, vecs[i].rpc, 0);
            step();
        end

        // ---------------- halt while waiting for a response ----------------
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("halt_in_wait", 32'(bus.imem_resp_ready), 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        step();
        chk("halt_sticky", 32'(bus.halted), 1);
        drive(1, 1, memfn(32'h8000_0000), 1, 0, 0, 0);
        step();
        chk("halt_deliver_valid", 32'(bus.out_valid), 1);
        chk("halt_deliver_pc", bus.out_pc, 32'h8000_0000);
        chk("halt_deliver_inst", bus.out_inst, 32'h0010_0093);
        drive(1, 0, 0, 1, 0, 0, 0);
        saw_req = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus.imem_req_valid) saw_req = 1'b1;
        end
        chk("halt_no_request", 32'(saw_req), 0);
        chk("halt_still_halted", 32'(bus.halted), 1);
        $display("halt sequence: halted=%0b req_seen=%0b", bus.halted, saw_req);
        do_reset();
        chk("halt_cleared_by_rst", 32'(bus.halted), 0);

        // ---------------- misaligned redirect ----------------
        drive(1, 0, 0, 0, 1, 32'h8000_0002, 0);
        step();
        drive(1, 0, 0, 0, 0, 0, 0);
`ifdef IFU_MISALIGN_CHECK_EN
        chk("misalign_no_req", 32'(bus.imem_req_valid), 0);
        step();
        chk("misalign_fault", 32'(bus.fetch_fault), 1);
        chk("misalign_halted", 32'(bus.halted), 1);
        step();
        step();
        chk("misalign_stays_idle", 32'(bus.imem_req_valid), 0);
`else
        chk("misalign_req_valid", 32'(bus.imem_req_valid), 1);
        chk("misalign_req_addr", bus.imem_req_addr, 32'h8000_0000);
        chk("misalign_fault_tied", 32'(bus.fetch_fault), 0);
`endif
        $display("misalign sequence: fault=%0b halted=%0b", bus.fetch_fault, bus.halted);

        // ---------------- reset asserted during WAIT ----------------
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("rstw_in_wait", 32'(bus.imem_resp_ready), 1);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        drive(0, 1, 32'h5555_AAAA, 1, 0, 0, 0);
        check_reset_vals("rstw");
        step();
        drive(1, 0, 0, 1, 0, 0, 0);
        chk("rstw_restart_req", 32'(bus.imem_req_valid), 1);
        chk("rstw_restart_addr", bus.imem_req_addr, 32'h8000_0000);
        chk("rstw_no_late_out", 32'(bus.out_valid), 0);
        step();
        drive(0, 1, memfn(32'h8000_0000), 0, 0, 0, 0);
        step();
        chk("rstw_out_valid", 32'(bus.out_valid), 1);
        chk("rstw_out_pc", bus.out_pc, 32'h8000_0000);
        chk("rstw_out_inst", bus.out_inst, 32'h0010_0093);
        $display("reset-in-wait sequence: out_pc=%h out_inst=%h", bus.out_pc, bus.out_inst);

        // ---------------- random traffic vs architectural model ----------------
        do_reset();
        model_pc   = 32'h8000_0000;
        pending    = 1'b0;
        pend_addr  = '0;
        lat        = 0;
        deliveries = 0;
        since_fire = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (pending && lat == 0) begin
                rvld_r  = 1'b1;
                rdata_r = memfn(pend_addr);
            end else begin
                rvld_r  = 1'b0;
                rdata_r = $urandom;
            end
            rrdy_r  = ($urandom_range(0, 9) < 7);
            ordy_r  = ($urandom_range(0, 9) < 6);
            redir_r = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 15) == 0) rpc_r = 32'hFFFF_FFFC;
            else rpc_r = 32'h8000_0000 + ($urandom_range(0, 255) << 2);
            drive(rrdy_r, rvld_r, rdata_r, ordy_r, redir_r, rpc_r, 0);

            if (bus.imem_req_valid)
                chk("rnd_req_addr", bus.imem_req_addr, model_pc & 32'hFFFF_FFFC);

            out_fire  = bus.out_valid & ordy_r;
            req_fire  = bus.imem_req_valid & rrdy_r;
            resp_fire = rvld_r & bus.imem_resp_ready;

            if (out_fire) begin
                chk("rnd_out_pc", bus.out_pc, model_pc);
                chk("rnd_out_inst", bus.out_inst, memfn(model_pc));
                $display("rnd deliver %0d: pc=%h inst=%h", deliveries, bus.out_pc, bus.out_inst);
                deliveries++;
                since_fire = 0;
            end else begin
                since_fire++;
            end

            if (redir_r) model_pc = rpc_r;
            else if (out_fire) model_pc = model_pc + 32'd4;

            if (resp_fire) pending = 1'b0;
            else if (pending && lat > 0) lat--;
            if (req_fire) begin
                pending   = 1'b1;
                pend_addr = bus.imem_req_addr;
                lat       = $urandom_range(0, 2);
            end

            if (since_fire > 300) begin
                n_vec++;
                n_err++;
                $display("FAIL rnd_watchdog: no delivery for %0d cycles, required at most 300", since_fire);
                break;
            end
            step();
        end
        chk("rnd_min_deliveries", 32'(deliveries >= 150), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
